ysyx_24080018_mem_arb: RTL and testbench

// - Shares the core's single memory port between IFU (instruction fetch) and LSU (load/store).
// - Two requesters with valid/ready requests and one-cycle response pulses. One memory master side.
// - Allows one outstanding transaction. Sits between IFU/LSU and the memory/bus model in the core top.

---
 rtl/ysyx_24080018_pkg.sv | 24 ++
 rtl/ysyx_24080018_arb_pick.sv | 29 ++
 rtl/ysyx_24080018_mem_arb.sv | 163 ++++++++++++++++
 tb/tb_ysyx_24080018_mem_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080018_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids, default widths.
// No logic; constants and types only.
// Imported by ysyx_24080018_mem_arb.
package ysyx_24080018_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_REQ  = ST_REQ,
      S_WAIT = ST_WAIT,
      S_RESP = ST_RESP
   } state_t;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24080018_arb_pick.sv
// Two-way IFU/LSU priority pick with anti-starvation bit update.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the grant is consumed and starve_next committed.
module ysyx_24080018_arb_pick (
   input  logic ifu_valid,
   input  logic lsu_valid,
   input  logic starve,
   output logic grant_ifu,
   output logic grant_lsu,
   output logic starve_next
);

   // LSU wins by default; a previously starved IFU wins once, which clears the bit.
   always_comb begin
      grant_ifu   = 1'b0;
      grant_lsu   = 1'b0;
      starve_next = starve;
      if (ifu_valid && (starve || !lsu_valid)) begin
         grant_ifu   = 1'b1;
         starve_next = 1'b0;
      end else if (lsu_valid) begin
         grant_lsu = 1'b1;
         if (ifu_valid) begin
            starve_next = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ysyx_24080018_mem_arb.sv
// Shares one memory port between IFU and LSU, one outstanding transaction (IDLE->REQ->WAIT->RESP).
// Latency: accept to resp_valid is 3 cycles minimum; req_ready only in IDLE; responses cannot stall.
// Optional YSYX_24080018_MEM_ARB_TIMEOUT_EN: WAIT gives up after TIMEOUT cycles with resp_err=1.
module ysyx_24080018_mem_arb
   import ysyx_24080018_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                resp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   state_t            state;
   logic              owner;
   logic              starve;
   logic              grant_ifu;
   logic              grant_lsu;
   logic              starve_next;
   logic              wait_done;
   logic              wait_err;
   logic [DATA_W-1:0] wait_data;

   ysyx_24080018_arb_pick u_pick (
      .ifu_valid   (ifu_req_valid),
      .lsu_valid   (lsu_req_valid),
      .starve      (starve),
      .grant_ifu   (grant_ifu),
      .grant_lsu   (grant_lsu),
      .starve_next (starve_next)
   );

   // Accept is combinational in IDLE and suppressed while reset is held.
   assign ifu_req_ready = !rst && (state == S_IDLE) && grant_ifu;
   assign lsu_req_ready = !rst && (state == S_IDLE) && grant_lsu;

`ifdef YSYX_24080018_MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt;

   // Counts WAIT cycles; zero on the first WAIT cycle, so CNT_LAST marks the TIMEOUT-th one.
   always_ff @(posedge clk) begin
      if (rst || state != S_WAIT) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   // Resolve how WAIT ends this cycle; a real response beats a coincident timeout.
   always_comb begin
      wait_done = mem_resp_valid;
      wait_err  = 1'b0;
      wait_data = mem_wen ? '0 : mem_rdata;
`ifdef YSYX_24080018_MEM_ARB_TIMEOUT_EN
      if (!mem_resp_valid && wait_cnt == CNT_LAST) begin
         wait_done = 1'b1;
         wait_err  = 1'b1;
         wait_data = '0;
      end
`endif
   end

   // Main FSM with registered memory request, payload latch and response pulses; rdata holds between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         owner          <= OWN_IFU;
         starve         <= 1'b0;
         mem_req_valid  <= 1'b0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         resp_err       <= 1'b0;
         ifu_rdata      <= '0;
         lsu_rdata      <= '0;
      end else begin
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         resp_err       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_ifu || grant_lsu) begin
                  starve        <= starve_next;
                  mem_req_valid <= 1'b1;
                  state         <= S_REQ;
                  if (grant_lsu) begin
                     owner     <= OWN_LSU;
                     mem_addr  <= lsu_addr;
                     mem_wen   <= lsu_wen;
                     mem_wdata <= lsu_wdata;
                     mem_wmask <= lsu_wmask;
                  end else begin
                     owner     <= OWN_IFU;
                     mem_addr  <= ifu_addr;
                     mem_wen   <= 1'b0;
                     mem_wdata <= '0;
                     mem_wmask <= '0;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_done) begin
                  resp_err <= wait_err;
                  state    <= S_RESP;
                  if (owner == OWN_LSU) begin
                     lsu_rdata      <= wait_data;
                     lsu_resp_valid <= 1'b1;
                  end else begin
                     ifu_rdata      <= wait_data;
                     ifu_resp_valid <= 1'b1;
                  end
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24080018_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter: table-driven cycle vectors plus hand-written corner sequences.
// Inputs are driven on the falling edge, outputs sampled 1ns later, before the next rising edge.
// Build with or without YSYX_24080018_MEM_ARB_TIMEOUT_EN; TIMEOUT is set to 8.
module tb_ysyx_24080018_mem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_addr;
   logic        ifu_resp_valid;
   logic [31:0] ifu_rdata;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [31:0] lsu_addr;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_resp_valid;
   logic [31:0] lsu_rdata;
   logic        resp_err;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ysyx_24080018_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_rdata      (ifu_rdata),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_addr       (lsu_addr),
      .lsu_wen        (lsu_wen),
      .lsu_wdata      (lsu_wdata),
      .lsu_wmask      (lsu_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_rdata      (lsu_rdata),
      .resp_err       (resp_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata)
   );

   // One cycle of stimulus and expected outputs; LSU requests in tables are loads, memory always ready.
   typedef struct {
      logic        iv;
      logic [31:0] ia;
      logic        lv;
      logic [31:0] la;
      logic        mrv;
      logic [31:0] mrd;
      logic        e_irdy;
      logic        e_lrdy;
      logic        e_mv;
      logic [31:0] e_ma;
      logic        e_irv;
      logic [31:0] e_ird;
      logic        e_lrv;
      logic [31:0] e_lrd;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic lv, input logic [31:0] la,
                               input logic mrv, input logic [31:0] mrd,
                               input logic e_irdy, input logic e_lrdy, input logic e_mv, input logic [31:0] e_ma,
                               input logic e_irv, input logic [31:0] e_ird, input logic e_lrv, input logic [31:0] e_lrd);
      vec_t v;
      v.iv = iv; v.ia = ia; v.lv = lv; v.la = la; v.mrv = mrv; v.mrd = mrd;
      v.e_irdy = e_irdy; v.e_lrdy = e_lrdy; v.e_mv = e_mv; v.e_ma = e_ma;
      v.e_irv = e_irv; v.e_ird = e_ird; v.e_lrv = e_lrv; v.e_lrd = e_lrd;
      return v;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ifu_req_valid  = 1'b0;
      ifu_addr       = '0;
      lsu_req_valid  = 1'b0;
      lsu_addr       = '0;
      lsu_wen        = 1'b0;
      lsu_wdata      = '0;
      lsu_wmask      = '0;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_rdata      = '0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic smp();
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, " ifu_req_ready"}, ifu_req_ready, 1'b0);
      chk1({tag, " lsu_req_ready"}, lsu_req_ready, 1'b0);
      chk1({tag, " mem_req_valid"}, mem_req_valid, 1'b0);
      chk1({tag, " ifu_resp_valid"}, ifu_resp_valid, 1'b0);
      chk1({tag, " lsu_resp_valid"}, lsu_resp_valid, 1'b0);
      chk1({tag, " resp_err"}, resp_err, 1'b0);
      chk({tag, " ifu_rdata"}, ifu_rdata, 32'h0);
      chk({tag, " lsu_rdata"}, lsu_rdata, 32'h0);
      chk({tag, " mem_addr"}, mem_addr, 32'h0);
   endtask

   task automatic run_tbl(input string tag, input vec_t t[$]);
      for (int i = 0; i < t.size(); i++) begin
         cyc();
         ifu_req_valid  = t[i].iv;
         ifu_addr       = t[i].ia;
         lsu_req_valid  = t[i].lv;
         lsu_addr       = t[i].la;
         lsu_wen        = 1'b0;
         mem_req_ready  = 1'b1;
         mem_resp_valid = t[i].mrv;
         mem_rdata      = t[i].mrd;
         smp();
         chk1($sformatf("%s[%0d] ifu_req_ready", tag, i), ifu_req_ready, t[i].e_irdy);
         chk1($sformatf("%s[%0d] lsu_req_ready", tag, i), lsu_req_ready, t[i].e_lrdy);
         chk1($sformatf("%s[%0d] mem_req_valid", tag, i), mem_req_valid, t[i].e_mv);
         if (t[i].e_mv) chk($sformatf("%s[%0d] mem_addr", tag, i), mem_addr, t[i].e_ma);
         chk1($sformatf("%s[%0d] ifu_resp_valid", tag, i), ifu_resp_valid, t[i].e_irv);
         chk($sformatf("%s[%0d] ifu_rdata", tag, i), ifu_rdata, t[i].e_ird);
         chk1($sformatf("%s[%0d] lsu_resp_valid", tag, i), lsu_resp_valid, t[i].e_lrv);
         chk($sformatf("%s[%0d] lsu_rdata", tag, i), lsu_rdata, t[i].e_lrd);
         chk1($sformatf("%s[%0d] resp_err", tag, i), resp_err, 1'b0);
      end
   endtask

   // Issue one LSU load from IDLE and complete it with the given data on the first WAIT cycle.
   task automatic lsu_load(input string tag, input logic [31:0] addr, input logic [31:0] data);
      cyc(); lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = 1'b0; mem_req_ready = 1'b1; smp();
      chk1({tag, " accept"}, lsu_req_ready, 1'b1);
      cyc(); lsu_req_valid = 1'b0; smp();
      chk({tag, " mem_addr"}, mem_addr, addr);
      cyc(); mem_resp_valid = 1'b1; mem_rdata = data; smp();
      cyc(); mem_resp_valid = 1'b0; mem_rdata = '0; smp();
      chk1({tag, " lsu_resp_valid"}, lsu_resp_valid, 1'b1);
      chk({tag, " lsu_rdata"}, lsu_rdata, data);
      chk1({tag, " resp_err"}, resp_err, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t t1[$];
      vec_t t2[$];

      // Case 1: IFU only; accept t0, mem_req_valid t1, response t2, resp_valid t3.
      t1.push_back(mk(1, 32'h8000_0000, 0, 0, 0, 0,             1, 0, 0, 0,             0, 0,             0, 0));
      t1.push_back(mk(0, 0,             0, 0, 0, 0,             0, 0, 1, 32'h8000_0000, 0, 0,             0, 0));
      t1.push_back(mk(0, 0,             0, 0, 1, 32'h0000_0413, 0, 0, 0, 0,             0, 0,             0, 0));
      t1.push_back(mk(0, 0,             0, 0, 0, 0,             0, 0, 0, 0,             1, 32'h0000_0413, 0, 0));
      t1.push_back(mk(0, 0,             0, 0, 0, 0,             0, 0, 0, 0,             0, 32'h0000_0413, 0, 0));

      // Case 2: simultaneous valids; LSU first, starved IFU next, then LSU again by default.
      t2.push_back(mk(1, 32'h8000_0004, 1, 32'h8000_2000, 0, 0,  0, 1, 0, 0,             0, 32'h413,       0, 0));
      t2.push_back(mk(1, 32'h8000_0004, 1, 32'h8000_2000, 0, 0,  0, 0, 1, 32'h8000_2000, 0, 32'h413,       0, 0));
      t2.push_back(mk(1, 32'h8000_0004, 1, 32'h8000_2000, 1, 32'h1111_2222, 0, 0, 0, 0,  0, 32'h413,       0, 0));
      t2.push_back(mk(1, 32'h8000_0004, 1, 32'h8000_2000, 0, 0,  0, 0, 0, 0,             0, 32'h413,       1, 32'h1111_2222));
      t2.push_back(mk(1, 32'h8000_0004, 1, 32'h8000_2000, 0, 0,  1, 0, 0, 0,             0, 32'h413,       0, 32'h1111_2222));
      t2.push_back(mk(0, 0,             1, 32'h8000_2000, 0, 0,  0, 0, 1, 32'h8000_0004, 0, 32'h413,       0, 32'h1111_2222));
      t2.push_back(mk(0, 0,             1, 32'h8000_2000, 1, 32'h3333_4444, 0, 0, 0, 0,  0, 32'h413,       0, 32'h1111_2222));
      t2.push_back(mk(0, 0,             1, 32'h8000_2000, 0, 0,  0, 0, 0, 0,             1, 32'h3333_4444, 0, 32'h1111_2222));
      t2.push_back(mk(1, 32'h8000_0008, 1, 32'h8000_2004, 0, 0,  0, 1, 0, 0,             0, 32'h3333_4444, 0, 32'h1111_2222));
      t2.push_back(mk(0, 0,             0, 0,             0, 0,  0, 0, 1, 32'h8000_2004, 0, 32'h3333_4444, 0, 32'h1111_2222));
      t2.push_back(mk(0, 0,             0, 0,             1, 32'h5555_6666, 0, 0, 0, 0,  0, 32'h3333_4444, 0, 32'h1111_2222));
      t2.push_back(mk(0, 0,             0, 0,             0, 0,  0, 0, 0, 0,             0, 32'h3333_4444, 1, 32'h5555_6666));
      t2.push_back(mk(0, 0,             0, 0,             0, 0,  0, 0, 0, 0,             0, 32'h3333_4444, 0, 32'h5555_6666));

      // Reset with an IFU request pending: ready must stay low while reset is held.
      idle_inputs();
      rst = 1'b1;
      cyc(); ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; smp();
      chk1("reset ifu_req_ready", ifu_req_ready, 1'b0);
      cyc(); ifu_req_valid = 1'b0; rst = 1'b0; smp();
      chk_all_zero("reset");

      run_tbl("case1", t1);
      run_tbl("case2", t2);

      // Case 3: store with memory stalling 4 cycles; payload must stay latched.
      cyc(); rst = 1'b1; smp();
      cyc(); rst = 1'b0;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; mem_req_ready = 1'b0; smp();
      chk1("case3 accept", lsu_req_ready, 1'b1);
      for (int k = 0; k < 4; k++) begin
         cyc(); lsu_req_valid = 1'b0; lsu_addr = 32'h1234_5678; lsu_wdata = 32'h0; lsu_wmask = 4'hF; smp();
         chk1($sformatf("case3 stall%0d mem_req_valid", k), mem_req_valid, 1'b1);
         chk($sformatf("case3 stall%0d mem_addr", k), mem_addr, 32'h8000_1000);
         chk($sformatf("case3 stall%0d mem_wdata", k), mem_wdata, 32'hDEAD_BEEF);
         chk($sformatf("case3 stall%0d mem_wmask", k), {28'h0, mem_wmask}, 32'h3);
         chk1($sformatf("case3 stall%0d mem_wen", k), mem_wen, 1'b1);
      end
      cyc(); mem_req_ready = 1'b1; smp();
      chk1("case3 req still valid", mem_req_valid, 1'b1);
      cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; smp();
      chk1("case3 wait mem_req_valid", mem_req_valid, 1'b0);
      cyc(); mem_resp_valid = 1'b0; mem_rdata = '0; smp();
      chk1("case3 lsu_resp_valid", lsu_resp_valid, 1'b1);
      chk("case3 lsu_rdata", lsu_rdata, 32'h0);
      chk1("case3 ifu_resp_valid", ifu_resp_valid, 1'b0);
      cyc(); smp();
      chk1("case3 pulse width", lsu_resp_valid, 1'b0);

      // Case 4: reset during WAIT, stale response two cycles later must be dropped.
      idle_inputs();
      cyc(); lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; smp();
      chk1("case4 accept", lsu_req_ready, 1'b1);
      cyc(); lsu_req_valid = 1'b0; smp();
      chk1("case4 req", mem_req_valid, 1'b1);
      cyc(); rst = 1'b1; smp();
      cyc(); rst = 1'b0; smp();
      chk_all_zero("case4 after reset");
      cyc(); smp();
      cyc(); mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678; smp();
      cyc(); mem_resp_valid = 1'b0; mem_rdata = '0; smp();
      chk1("case4 stale lsu_resp_valid", lsu_resp_valid, 1'b0);
      chk1("case4 stale ifu_resp_valid", ifu_resp_valid, 1'b0);
      chk("case4 stale lsu_rdata", lsu_rdata, 32'h0);
      chk1("case4 stale mem_req_valid", mem_req_valid, 1'b0);
      lsu_load("case4 next", 32'h8000_3004, 32'hCAFE_F00D);

      // Cases 5/6: memory never answers.
      idle_inputs();
      cyc(); lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4000; smp();
      chk1("case5 accept", lsu_req_ready, 1'b1);
      cyc(); lsu_req_valid = 1'b0; smp();
      chk1("case5 req", mem_req_valid, 1'b1);
      for (int k = 0; k < 8; k++) begin
         cyc(); smp();
         chk1($sformatf("case5 wait%0d lsu_resp_valid", k), lsu_resp_valid, 1'b0);
         chk1($sformatf("case5 wait%0d resp_err", k), resp_err, 1'b0);
      end
`ifdef YSYX_24080018_MEM_ARB_TIMEOUT_EN
      cyc(); smp();
      chk1("case5 timeout lsu_resp_valid", lsu_resp_valid, 1'b1);
      chk1("case5 timeout resp_err", resp_err, 1'b1);
      chk("case5 timeout lsu_rdata", lsu_rdata, 32'h0);
      cyc(); mem_resp_valid = 1'b1; mem_rdata = 32'h9999_9999; smp();
      chk1("case5 late resp_err", resp_err, 1'b0);
      chk1("case5 late lsu_resp_valid", lsu_resp_valid, 1'b0);
      cyc(); mem_resp_valid = 1'b0; mem_rdata = '0; smp();
      chk1("case5 late ignored", lsu_resp_valid, 1'b0);
      lsu_load("case5 next", 32'h8000_4004, 32'h0BAD_CAFE);
`else
      for (int k = 0; k < 20; k++) begin
         cyc(); ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010; smp();
         chk1($sformatf("case6 hang%0d ifu_req_ready", k), ifu_req_ready, 1'b0);
         chk1($sformatf("case6 hang%0d lsu_resp_valid", k), lsu_resp_valid, 1'b0);
         chk1($sformatf("case6 hang%0d resp_err", k), resp_err, 1'b0);
      end
      cyc(); ifu_req_valid = 1'b0; rst = 1'b1; smp();
      cyc(); rst = 1'b0; smp();
      chk1("case6 reset mem_req_valid", mem_req_valid, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
